// File: rtl/shift_reg_pkg.sv
// Shared constants for the shift-register sequencer: mode encodings driven
// onto the universal shift register and the sequencer's FSM state codes.
package shift_reg_pkg;

    // Mode select seen by univ_shift_reg
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;  // MSB_IN enters at the MSB
    localparam logic [1:0] MODE_SHL  = 2'b10;  // LSB_IN enters at the LSB
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Shift direction for a captured dir bit: 0 = LSB first, 1 = MSB first
    function automatic logic [1:0] shift_mode(input logic msb_first);
        return msb_first ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shift_reg_seq.sv
// Full-duplex serializer/deserializer sequencer. Accepts a word on a
// valid/ready handshake, parallel-loads it into the neighbouring
// univ_shift_reg, shifts it out over n cycles while sdi shifts in from the
// opposite end, and presents the received word for one cycle in DONE.
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [n-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic         dir,
    input  logic         sdi,
    output logic         sdo,
    output logic [n-1:0] rx_data,
    output logic         rx_valid,
    output logic         busy,
    output logic [1:0]   s,
    output logic [n-1:0] I,
    output logic         MSB_IN,
    output logic         LSB_IN,
    input  logic [n-1:0] Q
);

    localparam int             CW       = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(n - 1);

    logic [1:0]    state_q, state_d;
    logic [n-1:0]  word_q, word_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  rx_data_q, rx_data_d;

    // Next-state logic: handshake capture, bit counting, receive capture
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        rx_data_d = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    word_d  = tx_data;
                    dir_d   = dir;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // The shift register takes its last bit on this same
                    // edge, so capture the value Q is about to become; that
                    // way rx_data already holds all n bits during DONE.
                    rx_data_d = dir_q ? {Q[n-2:0], sdi} : {sdi, Q[n-1:1]};
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin  // ST_DONE
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        s        = MODE_HOLD;
        sdo      = 1'b0;
        MSB_IN   = 1'b0;
        LSB_IN   = 1'b0;
        case (state_q)
            ST_LOAD: s = MODE_LOAD;
            ST_SHIFT: begin
                s      = shift_mode(dir_q);
                sdo    = dir_q ? Q[n-1] : Q[0];
                MSB_IN = dir_q ? 1'b0 : sdi;
                LSB_IN = dir_q ? sdi  : 1'b0;
            end
            default: s = MODE_HOLD;
        endcase
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign rx_valid = (state_q == ST_DONE);
    assign rx_data  = rx_data_q;
    assign I        = word_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq paired with a behavioural universal shift register.
module tb_shift_reg_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_b;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         dir;
    logic         sdi;
    logic         sdo;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic [1:0]   s;
    logic [N-1:0] I;
    logic         MSB_IN;
    logic         LSB_IN;
    logic [N-1:0] Q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_reg_seq #(.n(N)) dut (
        .clk(clk), .reset_b(reset_b), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dir(dir), .sdi(sdi), .sdo(sdo),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .s(s), .I(I),
        .MSB_IN(MSB_IN), .LSB_IN(LSB_IN), .Q(Q)
    );

    // Neighbouring universal shift register (shares reset_b)
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) Q <= '0;
        else case (s)
            2'b01:   Q <= {MSB_IN, Q[N-1:1]};
            2'b10:   Q <= {Q[N-2:0], LSB_IN};
            2'b11:   Q <= I;
            default: Q <= Q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bit i of sdi lands at position i (LSB first) or N-1-i (MSB first)
    function automatic logic [N-1:0] model_rx(input logic d, input logic [N-1:0] bits);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[d ? N-1-i : i] = bits[i];
        return r;
    endfunction

    // Reference: i-th serial output bit in time order
    function automatic logic [N-1:0] model_sdo(input logic d, input logic [N-1:0] w);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = w[d ? N-1-i : i];
        return r;
    endfunction

    // One full transfer; called at a falling edge with the block idle.
    // hold keeps tx_valid up and presents (nw, nd) after the accept.
    task automatic xfer(input logic [N-1:0] w, input logic d, input logic [N-1:0] bits,
                        input logic [N-1:0] erx, input logic [N-1:0] esdo,
                        input logic hold, input logic [N-1:0] nw, input logic nd);
        tx_data = w; dir = d; tx_valid = 1'b1; #1;
        chk("idle_ready", 32'(tx_ready), 32'(1));
        @(posedge clk); #1;
        if (hold) begin
            tx_data = nw; dir = nd;
        end else begin
            tx_valid = 1'b0; tx_data = ~w; dir = ~d;
        end
        @(negedge clk);
        chk("load_s", 32'(s), 32'(2'b11));
        chk("load_I", 32'(I), 32'(w));
        chk("load_ready", 32'(tx_ready), 32'(0));
        chk("load_busy", 32'(busy), 32'(1));
        chk("load_sdo", 32'(sdo), 32'(0));
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            sdi = bits[i]; #1;
            chk("shift_s", 32'(s), d ? 32'(2'b10) : 32'(2'b01));
            chk("shift_sdo", 32'(sdo), 32'(esdo[i]));
            chk("shift_msbin", 32'(MSB_IN), d ? 32'(0) : 32'(bits[i]));
            chk("shift_lsbin", 32'(LSB_IN), d ? 32'(bits[i]) : 32'(0));
            chk("shift_rxv", 32'(rx_valid), 32'(0));
            chk("shift_ready", 32'(tx_ready), 32'(0));
        end
        @(negedge clk);
        chk("done_rxv", 32'(rx_valid), 32'(1));
        chk("done_rx", 32'(rx_data), 32'(erx));
        chk("done_s", 32'(s), 32'(0));
        chk("done_busy", 32'(busy), 32'(1));
        chk("done_sdo", 32'(sdo), 32'(0));
        @(negedge clk);
        chk("post_rxv", 32'(rx_valid), 32'(0));
        chk("post_ready", 32'(tx_ready), 32'(1));
        chk("post_rx_hold", 32'(rx_data), 32'(erx));
    endtask

    typedef struct {
        logic [N-1:0] w;
        logic         d;
        logic [N-1:0] bits;  // sdi bit i sent in SHIFT cycle i
        logic [N-1:0] erx;
        logic [N-1:0] esdo;  // sdo bit i seen in SHIFT cycle i
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[5];
        logic [N-1:0] w, b, w2;
        logic d, d2;
        vt[0] = '{4'b1001, 1'b0, 4'b1011, 4'b1011, 4'b1001};
        vt[1] = '{4'b1101, 1'b1, 4'b1100, 4'b0011, 4'b1011};
        vt[2] = '{4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000};
        vt[3] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b1111};
        vt[4] = '{4'b0110, 1'b1, 4'b0001, 4'b1000, 4'b0110};

        reset_b = 1'b0; tx_data = '0; tx_valid = 1'b0; dir = 1'b0; sdi = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_b = 1'b1; #1;
        chk("rst_ready", 32'(tx_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_I", 32'(I), 32'(0));
        chk("rst_msbin", 32'(MSB_IN), 32'(0));
        chk("rst_lsbin", 32'(LSB_IN), 32'(0));
        chk("rst_sdo", 32'(sdo), 32'(0));
        chk("rst_rx", 32'(rx_data), 32'(0));
        chk("rst_rxv", 32'(rx_valid), 32'(0));
        @(negedge clk);

        // Directed vectors
        for (int k = 0; k < 5; k++)
            xfer(vt[k].w, vt[k].d, vt[k].bits, vt[k].erx, vt[k].esdo, 1'b0, '0, 1'b0);

        // Back-to-back with tx_valid held; second word changes mid-transfer
        xfer(4'b1001, 1'b0, 4'b1011, 4'b1011, 4'b1001, 1'b1, 4'b1101, 1'b1);
        xfer(4'b1101, 1'b1, 4'b1100, 4'b0011, 4'b1011, 1'b0, '0, 1'b0);

        // Randomised transfers against the reference model
        for (int k = 0; k < 20; k++) begin
            w = N'($urandom); d = 1'($urandom); b = N'($urandom);
            w2 = N'($urandom); d2 = 1'($urandom);
            xfer(w, d, b, model_rx(d, b), model_sdo(d, w), 1'b0, '0, 1'b0);
            if (k % 4 == 0)
                xfer(w2, d2, ~b, model_rx(d2, ~b), model_sdo(d2, w2), 1'b0, '0, 1'b0);
        end

        // Reset during SHIFT cycle 2
        tx_data = 4'b1010; dir = 1'b0; tx_valid = 1'b1;
        @(posedge clk); #1; tx_valid = 1'b0;
        repeat (3) @(negedge clk);  // LOAD, SHIFT0, SHIFT1
        @(negedge clk);             // SHIFT2
        chk("mid_busy_before", 32'(busy), 32'(1));
        reset_b = 1'b0; #1;
        chk("mid_ready", 32'(tx_ready), 32'(1));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_s", 32'(s), 32'(0));
        chk("mid_Q", 32'(Q), 32'(0));
        chk("mid_rx", 32'(rx_data), 32'(0));
        chk("mid_sdo", 32'(sdo), 32'(0));
        @(negedge clk); reset_b = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("mid_post_rxv", 32'(rx_valid), 32'(0));
            chk("mid_post_ready", 32'(tx_ready), 32'(1));
        end

        // Block is usable again after the aborted transfer
        xfer(4'b0011, 1'b1, 4'b0101, model_rx(1'b1, 4'b0101), model_sdo(1'b1, 4'b0011), 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Sequencer that sits directly upstream of `univ_shift_reg` and drives its mode select, parallel load, and serial inputs. It accepts a parallel word on a valid/ready handshake and loads it into the shift register. It then shifts the word out serially over n cycles while shifting serial input bits in from the opposite end, and presents the captured word when done. Together with `univ_shift_reg` it forms a full-duplex n-bit serializer/deserializer, SPI-data-path style.

## Interface
- `n`, 4, word width. Must match `univ_shift_reg`; n ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `tx_data`  in  n  word to transmit.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  block idle, can accept a word.
- `dir`  in  1  0 = LSB first (shift right), 1 = MSB first (shift left); sampled at accept.
- `sdi`  in  1  serial data in.
- `sdo`  out  1  serial data out.
- `rx_data`  out  n  received word (registered).
- `rx_valid`  out  1  one-cycle pulse, `rx_data` new.
- `busy`  out  1  high in any state other than IDLE.
- `s`  out  2  mode to shift reg: 00 hold, 01 shift right (`MSB_IN` enters MSB), 10 shift left (`LSB_IN` enters LSB), 11 parallel load.
- `I`  out  n  parallel load value to shift reg.
- `MSB_IN`  out  1  serial in for right shift.
- `LSB_IN`  out  1  serial in for left shift.
- `Q`  in  n  shift reg contents.

## Operation
- Moore FSM, states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `tx_ready`=1, `s`=00.
  - On `tx_valid`&&`tx_ready` at an edge: capture `tx_data` into `word_r` and `dir` into `dir_r`, then go to LOAD.
- **LOAD**
  - `s`=11, `I`=`word_r`.
  - Next state SHIFT; clear the bit counter `cnt`.
- **SHIFT**
  - `s`=01 if `dir_r`=0, else 10.
  - `MSB_IN`=`sdi` when `dir_r`=0, else 0.
  - `LSB_IN`=`sdi` when `dir_r`=1, else 0.
  - `sdo`=`Q[0]` (dir 0) or `Q[n-1]` (dir 1), combinational from `Q`.
  - `cnt` increments each cycle; after n SHIFT cycles (`cnt`==n-1), go to DONE.
- **DONE**
  - `s`=00.
  - `rx_data` ← `Q` at the entering edge, so it holds the n received bits. First received bit ends at the LSB (dir 0) or MSB (dir 1).
  - `rx_valid`=1 for this one cycle.
  - Next state IDLE.
- **Static outputs**
  - `I`=`word_r` in all states (don't-care outside LOAD).
  - `sdo`=0 outside SHIFT.
- **Other rules**
  - `tx_valid` while busy is ignored, not queued; the upstream source holds it.
  - `dir` and `tx_data` changes after accept have no effect.
  - `cnt` width is `$clog2(n)`; it never wraps within a transfer.

## Timing
- Reset (async assert, sync deassert by upstream), all values:
  - state IDLE; `tx_ready`=1; `busy`=0.
  - `s`=00; `I`=0; `MSB_IN`=`LSB_IN`=0; `sdo`=0.
  - `rx_data`=0; `rx_valid`=0; `word_r`=0; `dir_r`=0; `cnt`=0.
- Accept at edge k:
  - LOAD during cycle k..k+1.
  - SHIFT cycles k+1..k+n.
  - DONE cycle k+n+1 (`rx_valid` high).
  - IDLE and `tx_ready`=1 from edge k+n+2.
- Throughput: one word per n+2 cycles.
- `sdi` is sampled by the shift reg at each SHIFT-cycle edge. Bit i (i=0..n-1) is sampled at edge k+2+i.
- `sdo` bit i is valid during SHIFT cycle i.
- Back-to-back: with `tx_valid` held, the next accept occurs at the first IDLE edge.
- Reset mid-transfer: immediate return to IDLE.
  - `rx_valid` is not asserted and the partial word is discarded.
  - `univ_shift_reg` shares `reset_b`, so `Q`=0.

## Structure
- Shared package `shift_reg_pkg`:
  - mode constants `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11.
  - FSM state localparams.
- `univ_shift_reg` is instantiated beside this block at the next level up, not inside it.
- No sub-module; counter and FSM are inline.

## Test plan
n=4; each case pairs `shift_reg_seq` with `univ_shift_reg`.
- **Reset:** hold `reset_b`=0, then release → all outputs at reset values, `tx_ready`=1.
- **LSB-first full duplex:** `tx_data`=1001, `dir`=0, `sdi` sequence 1,1,0,1 →
  - `s`: 11 for one cycle, then 01 for 4 cycles.
  - `sdo` bits 1,0,0,1.
  - `rx_data`=1011, with `rx_valid` high for exactly 1 cycle at accept+5.
- **MSB-first:** `tx_data`=1101, `dir`=1, `sdi` 0,0,1,1 → `s`=10 in SHIFT, `sdo` 1,1,0,1, `rx_data`=0011.
- **Busy and back-to-back:**
  - `tx_valid` held through a transfer → the second word is accepted only at accept+6.
  - Changes to `tx_data`/`dir` mid-transfer do not affect the first word.
- **Reset mid-SHIFT:** `reset_b`=0 at SHIFT cycle 2 → IDLE next, no `rx_valid`, `Q`=0, `tx_ready`=1 after release.
